alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter: DEPTH, 4, number of reservation-station entries (power of two, 2..8).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  synchronous pipeline flush (mispredict).
REQ-005 disp_valid  in  1  dispatch request this cycle.
REQ-006 disp_op  in  5  ALU opcode (passed through unchanged).
REQ-007 disp_vj, disp_vk  in  32 each  operand values, valid when matching q*_busy low.
REQ-008 disp_qj_busy, disp_qk_busy  in  1 each  operand still pending on a producer tag.
REQ-009 disp_qj, disp_qk  in  4 each  producer tags.
REQ-010 disp_dest  in  4  destination tag of the instruction.
REQ-011 rs_full  out  1  no free entry; combinational from entry busy bits.
REQ-012 cdb_alu_done / cdb_alu_tag / cdb_alu_data  in  1/4/32  ALU result broadcast.
REQ-013 cdb_lsb_done / cdb_lsb_tag / cdb_lsb_data  in  1/4/32  load-store result broadcast.
REQ-014 alu_ready  out  1  issue strobe to ALU, registered.
REQ-015 a, b  out  32 each  issued operands, registered.
REQ-016 alu_op  out  5; tag  out  4  issued opcode and destination tag, registered.

Function
REQ-017 Each entry SHALL hold busy, op, vj, vk, qj, qk, qj_busy, qk_busy, dest.
REQ-018 Dispatch SHALL be accepted at an edge iff disp_valid=1, rs_full=0, flush=0; a disp_valid with rs_full=1 SHALL be ignored (no state change).
REQ-019 Accepted dispatch SHALL write the lowest-index non-busy entry.
REQ-020 Wakeup: at every edge, for each busy entry with qj_busy=1 and a done CDB whose tag equals qj, vj SHALL take that CDB data and qj_busy SHALL clear; identically for qk.
REQ-021 Same-cycle wakeup at dispatch: a dispatched operand whose tag matches a done CDB in the dispatch cycle SHALL be stored as ready with that CDB data.
REQ-022 Both CDBs done with the same matching tag: ALU CDB data SHALL win.
REQ-023 An entry is ready when busy=1, qj_busy=0, qk_busy=0 in registered state; wakeup in a cycle makes it selectable only from the following cycle.
REQ-024 Select SHALL pick the lowest-index ready entry; at most one issue per cycle.
REQ-025 On issue edge: alu_ready<=1, a<=vj, b<=vk, alu_op<=op, tag<=dest, entry busy<=0; if no ready entry alu_ready<=0 and a/b/alu_op/tag hold.
REQ-026 Latency: dispatch with both operands ready accepted at edge E SHALL produce alu_ready=1 after edge E+1; alu_ready SHALL be a single-cycle pulse per issued entry.
REQ-027 An entry freed at an edge SHALL be reusable by a dispatch at the next edge; rs_full SHALL drop after the issuing edge.
REQ-028 Freed entry and new dispatch at the same edge SHALL not alias: dispatch uses free state sampled before the edge.
REQ-029 flush=1 at an edge SHALL clear all busy bits and drive alu_ready<=0; flush has priority over dispatch, wakeup and issue.
REQ-030 CDB tags not matching any pending operand SHALL be ignored; done=0 SHALL never wake.

Reset
REQ-031 While rst=1: all busy bits 0, alu_ready=0, a=0, b=0, alu_op=0, tag=0; rs_full=0.
REQ-032 Reset mid-operation SHALL discard all entries immediately, independent of clk.

Verification
REQ-033 Ready dispatch op=0, vj=5, vk=7, dest=3 at edge E -> after E+1 alu_ready=1, a=5, b=7, alu_op=0, tag=3; after E+2 alu_ready=0.
REQ-034 Dispatch qj_busy=1 qj=9, vk=2, dest=4; later cdb_alu_done=1 tag=9 data=0x10 at edge W -> issue after W+1 with a=0x10, b=2, tag=4.
REQ-035 Fill 4 entries all pending -> rs_full=1; fifth disp_valid ignored; wake entry 2 -> issues, rs_full=0 after issue edge, next dispatch lands in entry 2.
REQ-036 Dispatch qk tag 6 while cdb_lsb_done=1 tag=6 data=0xAB same cycle -> stored ready, issues after next edge with b=0xAB.
REQ-037 Entries 1 and 3 ready simultaneously -> entry 1 issues first, entry 3 on following cycle; back-to-back alu_ready pulses.
REQ-038 flush=1 with 3 busy entries and one ready -> no issue after that edge, rs_full=0, all entries empty; rst mid-issue -> alu_ready=0 immediately.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station.
// Holds up to DEPTH dispatched ALU instructions. Each entry snoops the ALU
// and load-store result buses for its pending operands. The lowest-index
// entry whose operands are both present is issued to the ALU through
// registered outputs, at most one per cycle.
module alu_rs #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        disp_valid,
  input  logic [4:0]  disp_op,
  input  logic [31:0] disp_vj,
  input  logic [31:0] disp_vk,
  input  logic        disp_qj_busy,
  input  logic        disp_qk_busy,
  input  logic [3:0]  disp_qj,
  input  logic [3:0]  disp_qk,
  input  logic [3:0]  disp_dest,
  output logic        rs_full,
  input  logic        cdb_alu_done,
  input  logic [3:0]  cdb_alu_tag,
  input  logic [31:0] cdb_alu_data,
  input  logic        cdb_lsb_done,
  input  logic [3:0]  cdb_lsb_tag,
  input  logic [31:0] cdb_lsb_data,
  output logic        alu_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  alu_op,
  output logic [3:0]  tag
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] qj_busy_q, qj_busy_d;
  logic [DEPTH-1:0] qk_busy_q, qk_busy_d;
  logic [4:0]       op_q   [DEPTH];
  logic [4:0]       op_d   [DEPTH];
  logic [31:0]      vj_q   [DEPTH];
  logic [31:0]      vj_d   [DEPTH];
  logic [31:0]      vk_q   [DEPTH];
  logic [31:0]      vk_d   [DEPTH];
  logic [3:0]       qj_q   [DEPTH];
  logic [3:0]       qj_d   [DEPTH];
  logic [3:0]       qk_q   [DEPTH];
  logic [3:0]       qk_d   [DEPTH];
  logic [3:0]       dest_q [DEPTH];
  logic [3:0]       dest_d [DEPTH];

  // Issue port registers
  logic        alu_ready_q, alu_ready_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [3:0]  tag_q, tag_d;

  // Allocation / selection helpers
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    issue_idx;
  logic [DEPTH-1:0] ready_vec;
  logic             issue_valid;
  logic             disp_accept;

  // Dispatch operands after same-cycle bus snooping
  logic [32:0] disp_j_snoop;
  logic [32:0] disp_k_snoop;
  logic [31:0] disp_vj_eff;
  logic [31:0] disp_vk_eff;
  logic        disp_qj_pend;
  logic        disp_qk_pend;

  // Looks up a tag on both result buses; returns {hit, data}, ALU bus first.
  function automatic logic [32:0] cdb_snoop(
    input logic [3:0]  want,
    input logic        alu_done,
    input logic [3:0]  alu_tag,
    input logic [31:0] alu_data,
    input logic        lsb_done,
    input logic [3:0]  lsb_tag,
    input logic [31:0] lsb_data
  );
    logic [32:0] res;
    res = '0;
    if (alu_done && (alu_tag == want)) begin
      res = {1'b1, alu_data};
    end else if (lsb_done && (lsb_tag == want)) begin
      res = {1'b1, lsb_data};
    end
    return res;
  endfunction

  assign rs_full     = &busy_q;
  assign disp_accept = disp_valid && !rs_full && !flush;

  assign alu_ready = alu_ready_q;
  assign a         = a_q;
  assign b         = b_q;
  assign alu_op    = alu_op_q;
  assign tag       = tag_q;

  // Lowest-index free entry, taken from the pre-edge busy bits
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IW'(i);
      end
    end
  end

  // Lowest-index entry with both operands present in registered state
  always_comb begin
    ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;
    issue_valid = |ready_vec;
    issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        issue_idx = IW'(i);
      end
    end
  end

  // Resolve dispatched operands that are being broadcast this very cycle
  always_comb begin
    disp_j_snoop = cdb_snoop(disp_qj, cdb_alu_done, cdb_alu_tag, cdb_alu_data,
                             cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data);
    disp_k_snoop = cdb_snoop(disp_qk, cdb_alu_done, cdb_alu_tag, cdb_alu_data,
                             cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data);
    disp_vj_eff  = disp_vj;
    disp_qj_pend = disp_qj_busy;
    disp_vk_eff  = disp_vk;
    disp_qk_pend = disp_qk_busy;
    if (disp_qj_busy && disp_j_snoop[32]) begin
      disp_vj_eff  = disp_j_snoop[31:0];
      disp_qj_pend = 1'b0;
    end
    if (disp_qk_busy && disp_k_snoop[32]) begin
      disp_vk_eff  = disp_k_snoop[31:0];
      disp_qk_pend = 1'b0;
    end
  end

  // Entry next state: flush clears everything, otherwise wakeup, issue, dispatch
  always_comb begin
    logic [32:0] j_hit;
    logic [32:0] k_hit;
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    j_hit     = '0;
    k_hit     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      vj_d[i]   = vj_q[i];
      vk_d[i]   = vk_q[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      dest_d[i] = dest_q[i];
    end

    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        j_hit = cdb_snoop(qj_q[i], cdb_alu_done, cdb_alu_tag, cdb_alu_data,
                          cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data);
        k_hit = cdb_snoop(qk_q[i], cdb_alu_done, cdb_alu_tag, cdb_alu_data,
                          cdb_lsb_done, cdb_lsb_tag, cdb_lsb_data);
        if (busy_q[i] && qj_busy_q[i] && j_hit[32]) begin
          vj_d[i]      = j_hit[31:0];
          qj_busy_d[i] = 1'b0;
        end
        if (busy_q[i] && qk_busy_q[i] && k_hit[32]) begin
          vk_d[i]      = k_hit[31:0];
          qk_busy_d[i] = 1'b0;
        end
      end

      if (issue_valid) begin
        busy_d[issue_idx] = 1'b0;
      end

      if (disp_accept) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = disp_op;
        vj_d[free_idx]      = disp_vj_eff;
        vk_d[free_idx]      = disp_vk_eff;
        qj_d[free_idx]      = disp_qj;
        qk_d[free_idx]      = disp_qk;
        qj_busy_d[free_idx] = disp_qj_pend;
        qk_busy_d[free_idx] = disp_qk_pend;
        dest_d[free_idx]    = disp_dest;
      end
    end
  end

  // Issue port next state: one-cycle strobe, payload holds while idle
  always_comb begin
    alu_ready_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    alu_op_d    = alu_op_q;
    tag_d       = tag_q;
    if (!flush && issue_valid) begin
      alu_ready_d = 1'b1;
      a_d         = vj_q[issue_idx];
      b_d         = vk_q[issue_idx];
      alu_op_d    = op_q[issue_idx];
      tag_d       = dest_q[issue_idx];
    end
  end

  // Entry state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      qj_busy_q <= '0;
      qk_busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= op_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        dest_q[i] <= dest_d[i];
      end
    end
  end

  // Issue port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ready_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      alu_op_q    <= '0;
      tag_q       <= '0;
    end else begin
      alu_ready_q <= alu_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_op_q    <= alu_op_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: table of single-dispatch vectors plus
// hand-written multi-cycle sequences, with a scoreboard of expected issues.
module tb_alu_rs;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic [4:0]  disp_op;
  logic [31:0] disp_vj, disp_vk;
  logic        disp_qj_busy, disp_qk_busy;
  logic [3:0]  disp_qj, disp_qk, disp_dest;
  logic        rs_full;
  logic        cdb_alu_done, cdb_lsb_done;
  logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
  logic [31:0] cdb_alu_data, cdb_lsb_data;
  logic        alu_ready;
  logic [31:0] a, b;
  logic [4:0]  alu_op;
  logic [3:0]  tag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] vj, vk;
    logic        qjb, qkb;
    logic [3:0]  qj, qk, dest;
    logic        ad;
    logic [3:0]  at;
    logic [31:0] adata;
    logic        ld;
    logic [3:0]  lt;
    logic [31:0] ldata;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[6];

  alu_rs #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest),
    .rs_full(rs_full),
    .cdb_alu_done(cdb_alu_done), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_data(cdb_alu_data),
    .cdb_lsb_done(cdb_lsb_done), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_data(cdb_lsb_data),
    .alu_ready(alu_ready), .a(a), .b(b), .alu_op(alu_op), .tag(tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] op,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic qjb, input logic [3:0] qj,
                               input logic qkb, input logic [3:0] qk,
                               input logic [3:0] dest);
    disp_valid   = v;
    disp_op      = op;
    disp_vj      = vj;
    disp_vk      = vk;
    disp_qj_busy = qjb;
    disp_qj      = qj;
    disp_qk_busy = qkb;
    disp_qk      = qk;
    disp_dest    = dest;
  endtask

  task automatic setCdb(input logic ad, input logic [3:0] at, input logic [31:0] adata,
                        input logic ld, input logic [3:0] lt, input logic [31:0] ldata);
    cdb_alu_done = ad;
    cdb_alu_tag  = at;
    cdb_alu_data = adata;
    cdb_lsb_done = ld;
    cdb_lsb_tag  = lt;
    cdb_lsb_data = ldata;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    setCdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectIssue(input logic [31:0] ea, input logic [31:0] eb,
                             input logic [4:0] eop, input logic [3:0] etag);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.op = eop;
    e.tag = etag;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every issue strobe must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && alu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_issue actual a=0x%0h b=0x%0h tag=%0d expected no issue", a, b, tag);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_a", a, e.a);
        checkOutput("sb_b", b, e.b);
        checkOutput("sb_op", 32'(alu_op), 32'(e.op));
        checkOutput("sb_tag", 32'(tag), 32'(e.tag));
      end
    end
  end

  // Global time bound
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    idle();

    vecs[0] = '{default: '0, op: 5'd0, vj: 32'd5, vk: 32'd7, dest: 4'd3,
                exp_a: 32'd5, exp_b: 32'd7};
    vecs[1] = '{default: '0, op: 5'h1F, vj: 32'hFFFF_FFFF, vk: 32'd0, dest: 4'd15,
                exp_a: 32'hFFFF_FFFF, exp_b: 32'd0};
    vecs[2] = '{default: '0, op: 5'd2, vj: 32'd1, vk: 32'hDEAD, qkb: 1'b1, qk: 4'd6, dest: 4'd2,
                ld: 1'b1, lt: 4'd6, ldata: 32'hAB, exp_a: 32'd1, exp_b: 32'hAB};
    vecs[3] = '{default: '0, op: 5'd3, vj: 32'hBAD, vk: 32'd3, qjb: 1'b1, qj: 4'd7, dest: 4'd8,
                ad: 1'b1, at: 4'd7, adata: 32'h111, ld: 1'b1, lt: 4'd7, ldata: 32'h222,
                exp_a: 32'h111, exp_b: 32'd3};
    vecs[4] = '{default: '0, op: 5'd4, vj: 32'hBAD, vk: 32'hBAD, qjb: 1'b1, qj: 4'd2,
                qkb: 1'b1, qk: 4'd2, dest: 4'd9, ad: 1'b1, at: 4'd2, adata: 32'h55,
                ld: 1'b1, lt: 4'd2, ldata: 32'h66, exp_a: 32'h55, exp_b: 32'h55};
    vecs[5] = '{default: '0, op: 5'd5, vj: 32'hBAD, vk: 32'hBAD, qjb: 1'b1, qj: 4'd4,
                qkb: 1'b1, qk: 4'd5, dest: 4'd1, ad: 1'b1, at: 4'd4, adata: 32'hA,
                ld: 1'b1, lt: 4'd5, ldata: 32'hB, exp_a: 32'hA, exp_b: 32'hB};

    // Reset values
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("reset_a", a, 32'd0);
    checkOutput("reset_b", b, 32'd0);
    checkOutput("reset_alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset_tag", 32'(tag), 32'd0);
    checkOutput("reset_rs_full", 32'(rs_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table: single dispatch, issue exactly one edge after acceptance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].qjb, vecs[i].qj,
                    vecs[i].qkb, vecs[i].qk, vecs[i].dest);
      setCdb(vecs[i].ad, vecs[i].at, vecs[i].adata, vecs[i].ld, vecs[i].lt, vecs[i].ldata);
      expectIssue(vecs[i].exp_a, vecs[i].exp_b, vecs[i].op, vecs[i].dest);
      tick();
      idle();
      checkOutput($sformatf("vec%0d_not_yet", i), 32'(alu_ready), 32'd0);
      tick();
      checkOutput($sformatf("vec%0d_issue", i), 32'(alu_ready), 32'd1);
      tick();
      checkOutput($sformatf("vec%0d_pulse_end", i), 32'(alu_ready), 32'd0);
    end

    // Pending operand woken later; done=0 and foreign tags must not wake it
    applyStimulus(1'b1, 5'd3, 32'hBAD, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0, 4'd4);
    tick();
    idle();
    setCdb(1'b0, 4'd9, 32'hFF, 1'b1, 4'd8, 32'hEE);
    checkOutput("wake_wait0", 32'(alu_ready), 32'd0);
    tick();
    setCdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    checkOutput("wake_wait1", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("wake_wait2", 32'(alu_ready), 32'd0);
    setCdb(1'b1, 4'd9, 32'h10, 1'b0, 4'd0, 32'd0);
    expectIssue(32'h10, 32'd2, 5'd3, 4'd4);
    tick();
    idle();
    checkOutput("wake_not_same_cycle", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("wake_issue", 32'(alu_ready), 32'd1);
    tick();
    checkOutput("wake_pulse_end", 32'(alu_ready), 32'd0);

    // Fill all entries pending, reject an extra dispatch, free and reuse entry 2
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 32'hBAD, 32'h100 + 32'(i), 1'b1, 4'(10 + i),
                    1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    checkOutput("full_set", 32'(rs_full), 32'd1);
    applyStimulus(1'b1, 5'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick();
    idle();
    checkOutput("full_ignored_full", 32'(rs_full), 32'd1);
    checkOutput("full_ignored_q0", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("full_ignored_q1", 32'(alu_ready), 32'd0);
    setCdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'h77);
    expectIssue(32'h77, 32'h102, 5'd3, 4'd2);
    tick();
    idle();
    checkOutput("full_after_wake", 32'(rs_full), 32'd1);
    checkOutput("full_wake_no_issue", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("full_issue", 32'(alu_ready), 32'd1);
    checkOutput("full_dropped", 32'(rs_full), 32'd0);
    applyStimulus(1'b1, 5'd5, 32'hBAD, 32'h104, 1'b1, 4'd14, 1'b0, 4'd0, 4'd5);
    tick();
    idle();
    checkOutput("reuse_full_again", 32'(rs_full), 32'd1);
    checkOutput("reuse_no_issue", 32'(alu_ready), 32'd0);

    // Two entries ready together: lower index first, back-to-back pulses
    setCdb(1'b1, 4'd10, 32'hA0, 1'b1, 4'd14, 32'hE0);
    expectIssue(32'hA0, 32'h100, 5'd1, 4'd0);
    expectIssue(32'hE0, 32'h104, 5'd5, 4'd5);
    tick();
    idle();
    checkOutput("pair02_wait", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("pair02_first", 32'(alu_ready), 32'd1);
    tick();
    checkOutput("pair02_second", 32'(alu_ready), 32'd1);
    tick();
    checkOutput("pair02_end", 32'(alu_ready), 32'd0);
    setCdb(1'b1, 4'd11, 32'hB1, 1'b1, 4'd13, 32'hD3);
    expectIssue(32'hB1, 32'h101, 5'd2, 4'd1);
    expectIssue(32'hD3, 32'h103, 5'd4, 4'd3);
    tick();
    idle();
    tick();
    checkOutput("pair13_first", 32'(alu_ready), 32'd1);
    tick();
    checkOutput("pair13_second", 32'(alu_ready), 32'd1);
    tick();
    checkOutput("pair13_end", 32'(alu_ready), 32'd0);
    checkOutput("pair13_empty", 32'(rs_full), 32'd0);

    // Flush with three busy entries, one of them ready, and a competing dispatch
    applyStimulus(1'b1, 5'd6, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd10);
    tick();
    applyStimulus(1'b1, 5'd6, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd11);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    tick();
    applyStimulus(1'b1, 5'd8, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    checkOutput("flush_no_issue", 32'(alu_ready), 32'd0);
    checkOutput("flush_rs_full", 32'(rs_full), 32'd0);
    setCdb(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
    tick();
    idle();
    tick();
    checkOutput("flush_stale_q0", 32'(alu_ready), 32'd0);
    tick();
    checkOutput("flush_stale_q1", 32'(alu_ready), 32'd0);
    applyStimulus(1'b1, 5'd1, 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'd12);
    tick();
    idle();
    checkOutput("flush_entries_empty", 32'(rs_full), 32'd0);

    // Reset while an issue strobe is high
    applyStimulus(1'b1, 5'd2, 32'h99, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    expectIssue(32'h99, 32'h88, 5'd2, 4'd7);
    tick();
    idle();
    tick();
    checkOutput("rst_mid_before", 32'(alu_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("rst_mid_a", a, 32'd0);
    checkOutput("rst_mid_b", b, 32'd0);
    checkOutput("rst_mid_tag", 32'(tag), 32'd0);
    checkOutput("rst_mid_rs_full", 32'(rs_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    setCdb(1'b1, 4'd15, 32'h1, 1'b0, 4'd0, 32'd0);
    tick();
    idle();
    tick();
    checkOutput("rst_discarded", 32'(alu_ready), 32'd0);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
